// File: rtl/vga_tile_renderer_if.sv
// Bundle between the tile renderer, the read port of the tile RAM and the VGA connector.
// The renderer holds the master side; the RAM/display side holds the slave side.
interface vga_tile_renderer_if;
  logic [7:0] vgaram_addrb;
  logic [3:0] vgaram_doutb;
  logic       hsync;
  logic       vsync;
  logic [7:0] rgb;
  logic       frame_tick;
  logic       in_vblank;

  modport master (
    output vgaram_addrb, hsync, vsync, rgb, frame_tick, in_vblank,
    input  vgaram_doutb
  );

  modport slave (
    input  vgaram_addrb, hsync, vsync, rgb, frame_tick, in_vblank,
    output vgaram_doutb
  );
endinterface

// File: rtl/vga_tile_renderer.sv
// VGA timing generator that scans a tile grid through a synchronous RAM read port
// and maps 4-bit tile codes to RGB332 pixels, with a once-per-frame vblank tick.
module vga_tile_renderer #(
  parameter int         H_ACTIVE   = 640,
  parameter int         H_FP       = 16,
  parameter int         H_SYNC     = 96,
  parameter int         H_BP       = 48,
  parameter int         V_ACTIVE   = 480,
  parameter int         V_FP       = 10,
  parameter int         V_SYNC     = 2,
  parameter int         V_BP       = 33,
  parameter int         GRID_COLS  = 15,
  parameter int         GRID_ROWS  = 10,
  parameter int         TILE_SHIFT = 5,
  parameter int         GRID_X0    = 80,
  parameter int         GRID_Y0    = 80,
  parameter logic [7:0] BORDER_RGB = 8'h49
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_tile_renderer_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] GX_FIRST = 10'(GRID_X0);
  localparam logic [9:0] GX_END   = 10'(GRID_X0 + (GRID_COLS << TILE_SHIFT));
  localparam logic [9:0] GY_FIRST = 10'(GRID_Y0);
  localparam logic [9:0] GY_END   = 10'(GRID_Y0 + (GRID_ROWS << TILE_SHIFT));
  localparam logic [9:0] COLS     = 10'(GRID_COLS);

  typedef struct packed {
    logic active;
    logic in_grid;
    logic hsync;
    logic vsync;
  } px_flags_t;

  localparam px_flags_t FLAGS_IDLE = '{active: 1'b0, in_grid: 1'b0, hsync: 1'b1, vsync: 1'b1};

  logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic [9:0] col, row;
  logic [7:0] addr0;
  logic [7:0] pix;
  px_flags_t  s0, s1, s2;

  function automatic logic [7:0] tile_colour(input logic [3:0] code);
    case (code)
      4'd0:                   return 8'hA8;
      4'd1, 4'd2, 4'd3, 4'd4: return 8'hFC;
      4'd6:                   return 8'h1C;
      4'd7:                   return 8'hF8;
      4'd8:                   return 8'hE0;
      default:                return 8'h00;
    endcase
  endfunction

  // Stage 0 decodes the counter value the registers are about to take, so the
  // registered address and flags line up with h_cnt/v_cnt in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path before any
    // conditional update; a path that leaves one unassigned infers a latch.
    v_nxt = v_cnt;
    h_nxt = h_cnt + 10'd1;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end

    s0.active  = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    s0.in_grid = (h_nxt >= GX_FIRST) && (h_nxt < GX_END) &&
                 (v_nxt >= GY_FIRST) && (v_nxt < GY_END);
    s0.hsync   = !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
    s0.vsync   = !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));

    col   = (h_nxt - GX_FIRST) >> TILE_SHIFT;
    row   = (v_nxt - GY_FIRST) >> TILE_SHIFT;
    addr0 = s0.in_grid ? 8'(row * COLS + col) : 8'd0;
  end

  // s2 is aligned with the RAM data, which arrives one clock after the address.
  always_comb begin
    pix = 8'h00;
    if (s2.active) pix = s2.in_grid ? tile_colour(bus.vgaram_doutb) : BORDER_RGB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt            <= '0;
      v_cnt            <= '0;
      s1               <= FLAGS_IDLE;
      s2               <= FLAGS_IDLE;
      bus.vgaram_addrb <= 8'd0;
      bus.rgb          <= 8'h00;
      bus.hsync        <= 1'b1;
      bus.vsync        <= 1'b1;
      bus.frame_tick   <= 1'b0;
      bus.in_vblank    <= 1'b0;
    end else begin
      h_cnt            <= h_nxt;
      v_cnt            <= v_nxt;
      s1               <= s0;
      s2               <= s1;
      bus.vgaram_addrb <= addr0;
      bus.rgb          <= pix;
      bus.hsync        <= s2.hsync;
      bus.vsync        <= s2.vsync;
      bus.frame_tick   <= (h_nxt == 10'd0) && (v_nxt == V_VIS);
      bus.in_vblank    <= (v_nxt >= V_VIS);
    end
  end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench for vga_tile_renderer on a scaled-down raster (4-px tiles) with a randomized
// tile RAM, compared cycle by cycle against a pixel-coordinate reference model.
module tb_vga_tile_renderer;

  localparam int HA = 80, HF = 4, HS = 8, HB = 4;
  localparam int VA = 56, VF = 2, VS = 2, VB = 3;
  localparam int TS = 2, TILE = 4, GX0 = 10, GY0 = 8, COLS = 15, ROWS = 10;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_tile_renderer_if bus ();

  vga_tile_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .GRID_COLS(COLS), .GRID_ROWS(ROWS), .TILE_SHIFT(TS),
    .GRID_X0(GX0), .GRID_Y0(GY0), .BORDER_RGB(8'h49)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Synchronous tile RAM read port: data one clock after the address.
  logic [3:0] mem [150];
  always @(posedge clk)
    bus.vgaram_doutb <= (bus.vgaram_addrb < 8'd150) ? mem[bus.vgaram_addrb] : 4'd0;

  int total = 0;
  int bad   = 0;
  int mh, mv, cyc;
  int hist_rgb [4], hist_hs [4], hist_vs [4], hist_h [4], hist_v [4];
  int hs_low, hs_win, vs_low, last_tick;

  typedef struct {
    int h;
    int v;
    int addr;
    int rgb;
  } point_t;

  point_t pts [9] = '{
    '{10, 8, 0, 'hFC},   // first pixel of tile 0
    '{13, 8, 0, 'hFC},   // last pixel of tile 0
    '{14, 8, 1, -1},
    '{9, 8, 0, 'h49},    // just left of the grid
    '{69, 47, 149, 'h1C},// last pixel of the last tile
    '{70, 47, 0, 'h49},  // just right of the grid
    '{10, 12, 15, 'hE0}, // first line of tile row 1
    '{10, 11, 0, 'hFC},  // last line of tile row 0
    '{38, 8, 7, 'h00}    // unused code 12
  };

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d, h=%0d v=%0d)", tag, got, exp, cyc, mh, mv);
    end
  endtask

  function automatic bit on_grid(input int h, input int v);
    return h >= GX0 && h < GX0 + COLS * TILE && v >= GY0 && v < GY0 + ROWS * TILE;
  endfunction

  function automatic int exp_addr(input int h, input int v);
    if (!on_grid(h, v)) return 0;
    return ((v - GY0) / TILE) * COLS + (h - GX0) / TILE;
  endfunction

  function automatic int colour_of(input int code);
    case (code)
      0:          return 'hA8;
      1, 2, 3, 4: return 'hFC;
      6:          return 'h1C;
      7:          return 'hF8;
      8:          return 'hE0;
      default:    return 'h00;
    endcase
  endfunction

  function automatic int exp_pixel(input int h, input int v);
    if (h >= HA || v >= VA) return 0;
    if (!on_grid(h, v)) return 'h49;
    return colour_of(int'(mem[exp_addr(h, v)]));
  endfunction

  function automatic bit pinned(input int k);
    return k == 0 || k == 7 || k == 15 || k == 149;
  endfunction

  // One pixel clock: called at a falling edge, compares, then advances the model.
  task automatic step();
    int slot, prev;
    slot = cyc % 4;
    prev = (cyc + 2) % 4;
    hist_rgb[slot] = exp_pixel(mh, mv);
    hist_hs[slot]  = !(mh >= HA + HF && mh < HA + HF + HS);
    hist_vs[slot]  = !(mv >= VA + VF && mv < VA + VF + VS);
    hist_h[slot]   = mh;
    hist_v[slot]   = mv;

    check("addr", bus.vgaram_addrb, exp_addr(mh, mv));
    check("frame_tick", bus.frame_tick, mh == 0 && mv == VA);
    check("in_vblank", bus.in_vblank, mv >= VA);
    if (cyc >= 3) begin
      check("rgb", bus.rgb, hist_rgb[prev]);
      check("hsync", bus.hsync, hist_hs[prev]);
      check("vsync", bus.vsync, hist_vs[prev]);
    end else begin
      check("rgb_startup", bus.rgb, 0);
      check("hsync_startup", bus.hsync, 1);
      check("vsync_startup", bus.vsync, 1);
    end

    foreach (pts[i]) begin
      if (pts[i].h == mh && pts[i].v == mv)
        check("pt_addr", bus.vgaram_addrb, pts[i].addr);
      if (cyc >= 3 && pts[i].rgb >= 0 && pts[i].h == hist_h[prev] && pts[i].v == hist_v[prev])
        check("pt_rgb", bus.rgb, pts[i].rgb);
    end

    if (cyc >= 3) begin
      hs_win++;
      if (!bus.hsync) hs_low++;
      if (!bus.vsync) vs_low++;
      if (hs_win == HT) begin
        check("hsync_per_line", hs_low, HS);
        hs_win = 0;
        hs_low = 0;
      end
    end
    if (bus.frame_tick) begin
      if (last_tick >= 0) begin
        check("tick_period", cyc - last_tick, FRAME);
        check("vsync_per_frame", vs_low, VS * HT);
      end
      last_tick = cyc;
      vs_low    = 0;
    end

    // Game logic rewrites part of the RAM during vblank.
    if (mh == 0 && mv == VA + 1) begin
      repeat (8) begin
        int k;
        k = $urandom_range(149);
        if (!pinned(k)) mem[k] = 4'($urandom_range(15));
      end
    end

    cyc++;
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
    @(negedge clk);
  endtask

  task automatic restart();
    rst_n     = 1'b1;
    mh        = 0;
    mv        = 0;
    cyc       = 0;
    hs_low    = 0;
    hs_win    = 0;
    vs_low    = 0;
    last_tick = -1;
  endtask

  initial begin
    int guard;
    for (int k = 0; k < 150; k++) mem[k] = 4'($urandom_range(15));
    mem[0]   = 4'd1;
    mem[7]   = 4'd12;
    mem[15]  = 4'd8;
    mem[149] = 4'd6;

    repeat (3) @(negedge clk);
    check("rst_rgb", bus.rgb, 0);
    check("rst_addr", bus.vgaram_addrb, 0);
    restart();
    repeat (FRAME + 1000) step();

    guard = 0;
    while (!(mh == 30 && mv == 20)) begin
      if (guard++ > FRAME) begin
        check("reach_reset_point", 0, 1);
        break;
      end
      step();
    end

    // Mid-frame asynchronous reset: outputs drop without waiting for a clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("midrst_rgb", bus.rgb, 0);
    check("midrst_hsync", bus.hsync, 1);
    check("midrst_vsync", bus.vsync, 1);
    check("midrst_addr", bus.vgaram_addrb, 0);
    check("midrst_tick", bus.frame_tick, 0);
    check("midrst_vblank", bus.in_vblank, 0);
    repeat (3) @(negedge clk);
    check("held_rgb", bus.rgb, 0);
    restart();
    repeat (3 * FRAME) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
